minmax_tracker: RTL and testbench
=================================

# minmax_tracker

Streaming min/max tracker for the ALU datapath. Accepts a packet of SIZE-bit unsigned samples over a valid/ready handshake, compares each sample against the running extremes using the `comparator` block, and on the packet's last beat presents the minimum, maximum and sample count on a result handshake. It sits directly downstream of operand sourcing and is the consumer of `comparator`'s `is_a_greater`/`equal` outputs.

## Interface
- `SIZE`, 8, sample width in bits (unsigned)
- `CNT_W`, 8, sample counter width
- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  reset; one clock, reset is asynchronous and active-high
- `in_valid`  input  1  sample present
- `in_ready`  output  1  block accepts sample this cycle
- `in_data`  input  SIZE  sample
- `in_last`  input  1  sample is final beat of packet
- `out_valid`  output  1  result present
- `out_ready`  input  1  consumer accepts result
- `out_min`  output  SIZE  packet minimum
- `out_max`  output  SIZE  packet maximum
- `out_count`  output  CNT_W  accepted beats, saturating
- `out_min_idx`, `out_max_idx`  output  CNT_W  beat index of extreme (only with `MINMAX_INDEX_EN`)

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state IDLE.
- Beat accepted when `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACCUM, 0 in DONE.
- IDLE, beat: min = max = `in_data`, count = 1; -> DONE if `in_last`, else -> ACCUM.
- ACCUM, beat: max updated to `in_data` if `in_data > max` (comparator a=`in_data`, b=max, `is_a_greater`); min updated if `min > in_data` (second comparator, a=min, b=`in_data`). Equal samples never replace: first occurrence wins. count += 1, saturating at 2^CNT_W-1. `in_last` -> DONE.
- DONE: `out_valid` = 1, outputs stable; `out_ready` -> IDLE. No sample accepted in DONE.
- Single-beat packet (`in_last` on first beat): min = max = sample, count = 1.
- Outputs registered; after the DONE handshake, values hold but are meaningless until next DONE.

## Timing
- Reset values: `in_ready` 0 while `rst` high, 1 in IDLE thereafter; `out_valid` 0, `out_min` 0, `out_max` 0, `out_count` 0, index outputs 0.
- Throughput: one sample per cycle in IDLE/ACCUM.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- Result handshake completes on the cycle `out_valid && out_ready`; `in_ready` returns the following cycle (one bubble per packet).
- `out_ready` held high while not in DONE has no effect.
- `rst` asserted mid-packet or in DONE: immediate return to IDLE, all registers cleared, partial packet discarded.
- `in_valid` low in ACCUM: state and registers hold indefinitely.

## Configuration
- `MINMAX_INDEX_EN` defined: `out_min_idx`/`out_max_idx` present; index = 0-based beat number at which the extreme was captured (first occurrence on ties), beat counter saturating identically to `out_count`.
- Not defined: index ports and their registers absent; all other behaviour identical.

## Structure
- Package `minmax_pkg`: state enum typedef (IDLE/ACCUM/DONE), reset constants.
- Sub-module: `comparator` (existing, instantiated twice with `SIZE` passed through); no other sub-modules.

## Test plan
- Packet 0x10, 0x05, 0x7F, 0x05(last) -> out_min 0x05, out_max 0x7F, out_count 4, valid one cycle after last beat; with macro min_idx 1, max_idx 2.
- Single beat 0xA5 with `in_last` -> min = max = 0xA5, count 1.
- Ties 0x33 x3 -> min = max = 0x33, count 3; with macro both indices 0.
- `out_ready` held low 5 cycles in DONE -> outputs stable, `in_ready` 0, in_valid beats ignored; then handshake -> IDLE, next packet 0xFF, 0x00(last) gives min 0x00, max 0xFF.
- CNT_W=2, 6-beat packet -> count saturates at 3.
- `rst` pulsed after 2 beats of a packet -> all outputs 0, IDLE; new packet 0x02, 0x01(last) yields min 0x01, max 0x02, count 2.

Source files
------------

// File: rtl/minmax_pkg.sv
// minmax_pkg: shared FSM state type and reset constants for minmax_tracker
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_VALID = 1'b0;

endpackage

// File: rtl/comparator.sv
// comparator: unsigned magnitude compare of a against b
module comparator #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            is_a_greater,
    output logic            equal
);

    assign is_a_greater = a > b;
    assign equal        = a == b;

endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: streaming packet min/max/count tracker; define MINMAX_INDEX_EN to add beat indices of the extremes
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_min,
    output logic [SIZE-1:0]  out_max,
`ifdef MINMAX_INDEX_EN
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
`endif
    output logic [CNT_W-1:0] out_count
);

    state_t            state, state_n;
    logic              accept;
    logic              gt_max, eq_max, gt_min, eq_min;
    logic              upd_max, upd_min;
    logic              sat;
    logic [CNT_W-1:0]  count_n;

    comparator #(.SIZE(SIZE)) u_cmp_max (
        .a            (in_data),
        .b            (out_max),
        .is_a_greater (gt_max),
        .equal        (eq_max)
    );

    comparator #(.SIZE(SIZE)) u_cmp_min (
        .a            (out_min),
        .b            (in_data),
        .is_a_greater (gt_min),
        .equal        (eq_min)
    );

    assign in_ready  = !rst && (state != DONE);
    assign out_valid = (state == DONE) ? 1'b1 : RST_VALID;
    assign accept    = in_valid && in_ready;
    assign upd_max   = gt_max && !eq_max;
    assign upd_min   = gt_min && !eq_min;
    assign sat       = &out_count;
    assign count_n   = sat ? out_count : out_count + CNT_W'(1);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RST_STATE;
        else
            state <= state_n;
    end

    // next state: first beat opens a packet, last beat closes it, result handshake returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCUM: state_n = accept ? (in_last ? DONE : ACCUM) : state;
            DONE:        state_n = out_ready ? IDLE : DONE;
            default:     state_n = IDLE;
        endcase
    end

    // running extremes and saturating beat count; ties keep the earlier sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                out_min   <= in_data;
                out_max   <= in_data;
                out_count <= CNT_W'(1);
            end else begin
                if (upd_min) out_min <= in_data;
                if (upd_max) out_max <= in_data;
                out_count <= count_n;
            end
        end
    end

`ifdef MINMAX_INDEX_EN
    // beat index of each extreme; the current count is the 0-based index of the incoming beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_min_idx <= '0;
            out_max_idx <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                out_min_idx <= '0;
                out_max_idx <= '0;
            end else begin
                if (upd_min) out_min_idx <= out_count;
                if (upd_max) out_max_idx <= out_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: directed self-checking bench for minmax_tracker (CNT_W=8 and CNT_W=2 instances)
module tb_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       in_ready0, out_valid0, in_ready1, out_valid1;
    logic [7:0] min0, max0, cnt0, min1, max1;
    logic [1:0] cnt1;
`ifdef MINMAX_INDEX_EN
    logic [7:0] min_idx0, max_idx0;
    logic [1:0] min_idx1, max_idx1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    minmax_tracker #(.SIZE(8), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_min(min0), .out_max(max0),
`ifdef MINMAX_INDEX_EN
        .out_min_idx(min_idx0), .out_max_idx(max_idx0),
`endif
        .out_count(cnt0)
    );

    minmax_tracker #(.SIZE(8), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_min(min1), .out_max(max1),
`ifdef MINMAX_INDEX_EN
        .out_min_idx(min_idx1), .out_max_idx(max_idx1),
`endif
        .out_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic settle;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_out_valid", out_valid0, 0);
        check("hs_in_ready", in_ready0, 1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] c);
        check({tag, "_valid"}, out_valid0, 1);
        check({tag, "_in_ready"}, in_ready0, 0);
        check({tag, "_min"}, min0, mn);
        check({tag, "_max"}, max0, mx);
        check({tag, "_count"}, cnt0, c);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready0, 0);
        check("rst_out_valid", out_valid0, 0);
        check("rst_min", min0, 0);
        check("rst_max", max0, 0);
        check("rst_count", cnt0, 0);
`ifdef MINMAX_INDEX_EN
        check("rst_min_idx", min_idx0, 0);
        check("rst_max_idx", max_idx0, 0);
`endif
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready0, 1);

        beat(8'h10, 0); beat(8'h05, 0); beat(8'h7F, 0);
        @(negedge clk);
        check("p1_not_yet_valid", out_valid0, 0);
        in_data = 8'h05; in_last = 1'b1;
        settle;
        check_result("p1", 8'h05, 8'h7F, 8'd4);
        check("p1_count_sat2", cnt1, 3);
`ifdef MINMAX_INDEX_EN
        check("p1_min_idx", min_idx0, 1);
        check("p1_max_idx", max_idx0, 2);
`endif
        handshake;

        beat(8'hA5, 1); settle;
        check_result("single", 8'hA5, 8'hA5, 8'd1);
`ifdef MINMAX_INDEX_EN
        check("single_min_idx", min_idx0, 0);
        check("single_max_idx", max_idx0, 0);
`endif
        handshake;

        beat(8'h33, 0); beat(8'h33, 0); beat(8'h33, 1); settle;
        check_result("ties", 8'h33, 8'h33, 8'd3);
`ifdef MINMAX_INDEX_EN
        check("ties_min_idx", min_idx0, 0);
        check("ties_max_idx", max_idx0, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h99;
            check_result("stall", 8'h33, 8'h33, 8'd3);
        end
        in_valid = 1'b0;
        handshake;

        out_ready = 1'b1;
        beat(8'hFF, 0);
        @(negedge clk);
        check("rdy_high_accum_valid", out_valid0, 0);
        check("rdy_high_accum_in_ready", in_ready0, 1);
        in_data = 8'h00; in_last = 1'b1;
        settle;
        check_result("ff00", 8'h00, 8'hFF, 8'd2);
`ifdef MINMAX_INDEX_EN
        check("ff00_min_idx", min_idx0, 1);
        check("ff00_max_idx", max_idx0, 0);
`endif
        @(negedge clk);
        out_ready = 1'b0;
        check("ff00_released", out_valid0, 0);

        beat(8'd1, 0); beat(8'd2, 0); beat(8'd3, 0);
        settle;
        for (int i = 0; i < 3; i++) begin
            check("gap_out_valid", out_valid0, 0);
            check("gap_in_ready", in_ready0, 1);
            @(negedge clk);
        end
        check("gap_count_hold", cnt0, 3);
        beat(8'd4, 0); beat(8'd5, 0); beat(8'd6, 1); settle;
        check_result("six", 8'd1, 8'd6, 8'd6);
        check("six_count_sat2", cnt1, 3);
        check("six_max_w2", max1, 6);
`ifdef MINMAX_INDEX_EN
        check("six_max_idx", max_idx0, 5);
        check("six_max_idx_sat2", max_idx1, 3);
        check("six_min_idx", min_idx0, 0);
`endif
        handshake;

        beat(8'h40, 0); beat(8'h50, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready0, 0);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_min", min0, 0);
        check("midrst_max", max0, 0);
        check("midrst_count", cnt0, 0);
        check("midrst_count_w2", cnt1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_in_ready", in_ready0, 1);
        check("postrst_out_valid", out_valid0, 0);
        beat(8'h02, 0); beat(8'h01, 1); settle;
        check_result("after_rst", 8'h01, 8'h02, 8'd2);
`ifdef MINMAX_INDEX_EN
        check("after_rst_min_idx", min_idx0, 1);
        check("after_rst_max_idx", max_idx0, 0);
`endif
        handshake;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
